// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, widths and helpers for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  localparam int STALL_CNT_W = 16;

  // Index width that stays legal (>= 1 bit) even for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GNT_W  = idx_w(4);
  localparam int BEAT_W = idx_w(4);

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority encoder: first set request at or after ptr, cyclically
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  int cand;

  // Scan from the farthest offset back to ptr so the closest hit wins.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = 0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % N;
      if (req[cand]) idx = W'(cand);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the async FIFO write port
// Optional stall counter enabled by FIFO_WR_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic [WIDTH-1:0]         wdata,
  output logic                     winc,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic [STALL_CNT_W-1:0]   stall_cnt
);

  localparam int GW = $clog2(NREQ);
  localparam int BW = idx_w(BURST);

  state_t         state;
  logic [GW-1:0]  ptr;
  logic [BW-1:0]  beat_cnt;
  logic           pick_any;
  logic [GW-1:0]  pick_idx;
  logic           own;
  logic           g_valid;
  logic           xfer;
  logic [GW-1:0]  ptr_next;

  rr_pick #(.N(NREQ), .W(GW)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign own      = (state == OWN);
  assign g_valid  = req_valid[grant_id];
  assign xfer     = own & g_valid & ~wfull;
  assign ptr_next = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  // Write strobe and ready follow wfull combinationally so a full FIFO is never overrun.
  assign winc  = xfer;
  assign wdata = xfer ? req_data[int'(grant_id)*WIDTH +: WIDTH] : '0;
  assign busy  = own;

  always_comb begin
    req_ready = '0;
    if (own && !wfull) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= OWN;
          end
        end
        OWN: begin
          if (!g_valid || (xfer && beat_cnt == BW'(BURST - 1))) begin
            ptr      <= ptr_next;
            beat_cnt <= '0;
            state    <= IDLE;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_q <= '0;
    end else if (own && g_valid && wfull && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed-vector bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic                    CLK = 1'b0;
  logic                    RST;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    wfull;
  logic [WIDTH-1:0]        wdata;
  logic                    winc;
  logic [1:0]              grant_id;
  logic                    busy;
  logic [15:0]             stall_cnt;

  int nvec = 0;
  int nerr = 0;

  int cnt [NREQ] = '{default: 0};
  int cyc = 0;
  int log_n = 0;
  int log_w [512];
  int log_c [512];
  logic pend = 1'b0;
  int   pend_id = 0;

  int base;
  int w0;
  int exp_stall;

  always #5 CLK = ~CLK;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .wdata     (wdata),
    .winc      (winc),
    .grant_id  (grant_id),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  // Requester i presents word i*16 + (words already accepted from i).
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_src
    assign req_data[gi*WIDTH +: WIDTH] = WIDTH'(gi * 16 + cnt[gi]);
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (pend) cnt[pend_id] = cnt[pend_id] + 1;
      cyc = cyc + 1;
      #2;
      pend    = winc;
      pend_id = int'(grant_id);
      if (winc && log_n < 512) begin
        log_w[log_n] = int'(wdata);
        log_c[log_n] = cyc;
        log_n = log_n + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec = nvec + 1;
    if (got !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    req_valid = '0;
    wfull = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b0;
    req_valid = '0;
    wfull = 1'b0;
    repeat (2) @(negedge CLK);
    req_valid = '1;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_winc", winc, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_wdata", wdata, 0);
    check("rst_stall", stall_cnt, 0);

    // Reset release with all valid, then a full round-robin cycle plus wrap.
    @(negedge CLK);
    RST = 1'b1;
    base = log_n;
    #1;
    check("rel_idle_winc", winc, 0);
    @(negedge CLK);
    #1;
    check("first_winc", winc, 1);
    check("first_grant", grant_id, 0);
    check("first_ready", req_ready, 4'b0001);
    check("first_busy", busy, 1);
    for (int t = 0; t < 200 && log_n < base + 17; t++) @(negedge CLK);
    check("rr_count", (log_n >= base + 17), 1);
    for (int k = 0; k < 17; k++) begin
      check($sformatf("rr_word%0d", k), log_w[base + k],
            (k < 16) ? ((k / 4) * 16 + (k % 4)) : 4);
    end
    check("rr_bubble", log_c[base + 4] - log_c[base + 3], 2);

    // Sparse: req2 alone, then req1 found by wrapping from ptr 3.
    do_reset();
    req_valid = 4'b0100;
    @(negedge CLK); #1;
    check("sp_grant2", grant_id, 2);
    check("sp_ready2", req_ready, 4'b0100);
    @(negedge CLK);
    req_valid = 4'b0010;
    #1;
    check("sp_drop_winc", winc, 0);
    @(negedge CLK); #1;
    check("sp_bubble", busy, 0);
    @(negedge CLK); #1;
    check("sp_grant1", grant_id, 1);
    check("sp_busy1", busy, 1);

    // Sparse: after req2 releases, ptr=3 so req3 wins over req0/req1.
    do_reset();
    req_valid = 4'b0100;
    @(negedge CLK);
    @(negedge CLK);
    req_valid = 4'b1011;
    @(negedge CLK);
    @(negedge CLK); #1;
    check("sp_ptr3", grant_id, 3);

    // wfull stall for 5 cycles after beat 2.
    do_reset();
    w0 = log_n;
    req_valid = 4'b0001;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    wfull = 1'b1;
    #1;
    check("st_winc", winc, 0);
    check("st_ready", req_ready, 0);
    check("st_busy", busy, 1);
    check("st_grant", grant_id, 0);
    repeat (4) @(negedge CLK);
    #1;
    check("st_hold", busy, 1);
    @(negedge CLK);
    wfull = 1'b0;
    #1;
`ifdef FIFO_WR_STATS_EN
    exp_stall = 5;
`else
    exp_stall = 0;
`endif
    check("st_cnt", stall_cnt, exp_stall);
    check("st_resume", winc, 1);
    @(negedge CLK);
    @(negedge CLK); #1;
    check("st_release", busy, 0);
    check("st_words", log_n - w0, 4);

    // Early drop after one beat.
    do_reset();
    w0 = log_n;
    req_valid = 4'b0011;
    @(negedge CLK);
    @(negedge CLK);
    req_valid = 4'b0010;
    #1;
    check("ed_winc", winc, 0);
    @(negedge CLK);
    req_valid = 4'b0011;
    #1;
    check("ed_bubble", busy, 0);
    @(negedge CLK); #1;
    check("ed_grant", grant_id, 1);
    check("ed_words", log_n - w0, 1);

    // Reset asserted mid-burst at beat 2.
    do_reset();
    req_valid = 4'b1111;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("mr_winc", winc, 0);
    check("mr_busy", busy, 0);
    check("mr_grant", grant_id, 0);
    check("mr_ready", req_ready, 0);
    check("mr_wdata", wdata, 0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("mr_rel_winc", winc, 0);
    check("mr_rel_busy", busy, 0);
    @(negedge CLK); #1;
    check("mr_regrant", grant_id, 0);
    check("mr_rewinc", winc, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
